// File: rtl/dmem_port_arbiter.sv
// Data-RAM port arbiter: two requesters (m0 = pipeline mem stage, m1 = debug/DMA) share a
// single RAM port, round-robin, one access outstanding. Produces byte strobes and
// lane-replicated store data; returns the raw read word after the fixed RAM latency.
`timescale 1ns / 1ps

module dmem_port_arbiter #(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic              m0_req_write,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic [31:0]       m0_req_wdata,
  input  logic [1:0]        m0_req_size,
  output logic              m0_rsp_valid,
  output logic [31:0]       m0_rsp_rdata,
  output logic              m0_rsp_err,

  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic              m1_req_write,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic [31:0]       m1_req_wdata,
  input  logic [1:0]        m1_req_size,
  output logic              m1_rsp_valid,
  output logic [31:0]       m1_rsp_rdata,
  output logic              m1_rsp_err,

  output logic              ram_d_en,
  output logic [3:0]        ram_d_we,
  output logic [ADDR_W-1:0] ram_d_addr,
  output logic [31:0]       ram_d_wdata,
  input  logic [31:0]       ram_d_rdata
);

  localparam logic [2:0] LatM1 = 3'(RD_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic        init_done_q;
  logic        last_grant_q, last_grant_d;  // 1 = m1 was granted last
  logic [2:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;            // master the in-flight response belongs to
  logic        load_q, load_d;              // in-flight access is a legal load
  logic        err_q, err_d;                // in-flight access was illegal

  logic              gnt0, gnt1, gnt_any;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [1:0]        sel_size;
  logic              sel_illegal;

  // Grant decision and selection of the granted master's request fields
  always_comb begin
    logic grant_ok;
    grant_ok  = init_done_q && (state_q != StWait);
    // On contention, the master that was not granted last wins
    gnt0      = grant_ok && m0_req_valid && (!m1_req_valid || last_grant_q);
    gnt1      = grant_ok && m1_req_valid && (!m0_req_valid || !last_grant_q);
    gnt_any   = gnt0 || gnt1;
    sel_write = gnt1 ? m1_req_write : m0_req_write;
    sel_addr  = gnt1 ? m1_req_addr  : m0_req_addr;
    sel_wdata = gnt1 ? m1_req_wdata : m0_req_wdata;
    sel_size  = gnt1 ? m1_req_size  : m0_req_size;
    unique case (sel_size)
      2'd0:    sel_illegal = 1'b0;
      2'd1:    sel_illegal = sel_addr[0];
      2'd2:    sel_illegal = (sel_addr[1:0] != 2'b00);
      default: sel_illegal = 1'b1;
    endcase
  end

  // State register and per-access bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      init_done_q  <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= 3'd0;
      owner_q      <= 1'b0;
      load_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_done_q  <= 1'b1;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      load_q       <= load_d;
      err_q        <= err_d;
    end
  end

  // Next-state: a grant (IDLE or RESP) overrides the default progression
  always_comb begin
    logic legal_load;
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    load_d       = load_q;
    err_d        = err_q;
    legal_load   = !sel_write && !sel_illegal;
    unique case (state_q)
      StIdle: state_d = StIdle;
      StWait: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = StResp;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (gnt_any) begin
      last_grant_d = gnt1;
      owner_d      = gnt1;
      err_d        = sel_illegal;
      load_d       = legal_load;
      if (legal_load && (RD_LATENCY > 1)) begin
        state_d = StWait;
        cnt_d   = LatM1;
      end else begin
        state_d = StResp;
      end
    end
  end

  // Outputs: handshake, RAM command for the granted request, response routing
  always_comb begin
    logic rsp_on;
    m0_req_ready = gnt0;
    m1_req_ready = gnt1;
    ram_d_en     = gnt_any && !sel_illegal;
    ram_d_we     = 4'b0000;
    ram_d_addr   = '0;
    ram_d_wdata  = 32'd0;
    if (ram_d_en) begin
      ram_d_addr = {sel_addr[ADDR_W-1:2], 2'b00};
      unique case (sel_size)
        2'd0: begin
          ram_d_we    = 4'b0001 << sel_addr[1:0];
          ram_d_wdata = {4{sel_wdata[7:0]}};
        end
        2'd1: begin
          ram_d_we    = 4'b0011 << sel_addr[1:0];
          ram_d_wdata = {2{sel_wdata[15:0]}};
        end
        default: begin
          ram_d_we    = 4'b1111;
          ram_d_wdata = sel_wdata;
        end
      endcase
      if (!sel_write) begin
        ram_d_we = 4'b0000;
      end
    end

    rsp_on       = (state_q == StResp);
    m0_rsp_valid = rsp_on && !owner_q;
    m1_rsp_valid = rsp_on && owner_q;
    m0_rsp_err   = m0_rsp_valid && err_q;
    m1_rsp_err   = m1_rsp_valid && err_q;
    m0_rsp_rdata = (m0_rsp_valid && load_q) ? ram_d_rdata : 32'd0;
    m1_rsp_rdata = (m1_rsp_valid && load_q) ? ram_d_rdata : 32'd0;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: one instance at RD_LATENCY = 1 and one at RD_LATENCY = 3,
// each driven by directed and random requests and compared every cycle against a
// time-based model (grant window, round-robin owner, response due cycle).
`timescale 1ns / 1ps

module tb_dmem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance signals, index [k] = instance, [m] = master
  logic        rst_n     [2];
  logic        rv        [2][2];
  logic        rw        [2][2];
  logic [31:0] ra        [2][2];
  logic [31:0] rwd       [2][2];
  logic [1:0]  rsz       [2][2];
  logic        rdy       [2][2];
  logic        sv        [2][2];
  logic [31:0] sd        [2][2];
  logic        se        [2][2];
  logic        ram_en    [2];
  logic [3:0]  ram_we    [2];
  logic [31:0] ram_addr  [2];
  logic [31:0] ram_wdata [2];
  logic [31:0] ram_rdata [2];

  dmem_port_arbiter #(.RD_LATENCY(1), .ADDR_W(32)) u_dut_l1 (
    .clk(clk), .reset_n(rst_n[0]),
    .m0_req_valid(rv[0][0]), .m0_req_ready(rdy[0][0]), .m0_req_write(rw[0][0]),
    .m0_req_addr(ra[0][0]), .m0_req_wdata(rwd[0][0]), .m0_req_size(rsz[0][0]),
    .m0_rsp_valid(sv[0][0]), .m0_rsp_rdata(sd[0][0]), .m0_rsp_err(se[0][0]),
    .m1_req_valid(rv[0][1]), .m1_req_ready(rdy[0][1]), .m1_req_write(rw[0][1]),
    .m1_req_addr(ra[0][1]), .m1_req_wdata(rwd[0][1]), .m1_req_size(rsz[0][1]),
    .m1_rsp_valid(sv[0][1]), .m1_rsp_rdata(sd[0][1]), .m1_rsp_err(se[0][1]),
    .ram_d_en(ram_en[0]), .ram_d_we(ram_we[0]), .ram_d_addr(ram_addr[0]),
    .ram_d_wdata(ram_wdata[0]), .ram_d_rdata(ram_rdata[0])
  );

  dmem_port_arbiter #(.RD_LATENCY(3), .ADDR_W(32)) u_dut_l3 (
    .clk(clk), .reset_n(rst_n[1]),
    .m0_req_valid(rv[1][0]), .m0_req_ready(rdy[1][0]), .m0_req_write(rw[1][0]),
    .m0_req_addr(ra[1][0]), .m0_req_wdata(rwd[1][0]), .m0_req_size(rsz[1][0]),
    .m0_rsp_valid(sv[1][0]), .m0_rsp_rdata(sd[1][0]), .m0_rsp_err(se[1][0]),
    .m1_req_valid(rv[1][1]), .m1_req_ready(rdy[1][1]), .m1_req_write(rw[1][1]),
    .m1_req_addr(ra[1][1]), .m1_req_wdata(rwd[1][1]), .m1_req_size(rsz[1][1]),
    .m1_rsp_valid(sv[1][1]), .m1_rsp_rdata(sd[1][1]), .m1_rsp_err(se[1][1]),
    .ram_d_en(ram_en[1]), .ram_d_we(ram_we[1]), .ram_d_addr(ram_addr[1]),
    .ram_d_wdata(ram_wdata[1]), .ram_d_rdata(ram_rdata[1])
  );

  int tests;
  int fails;
  int cur;

  // Reference model state: cycle index since reset release, outstanding response
  int n;
  int lat;
  bit busy;
  int rsp_cyc;
  int rm;
  bit rload;
  bit rerr;
  int last;
  bit rd_hold;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (inst %0d, cycle %0d)",
               tag, obs, exp, cur, n);
    end
  endtask

  // Misaligned = address not a multiple of the access size; size 3 is reserved
  function automatic bit is_illegal(input logic [1:0] sz, input logic [31:0] a);
    int nb;
    if (sz == 2'd3) return 1'b1;
    nb = 1 << sz;
    return (a % nb) != 0;
  endfunction

  task automatic model_reset();
    n    = 0;
    busy = 1'b0;
    last = 1;
  endtask

  task automatic req(input int k, input int m, input bit wr, input logic [31:0] a,
                     input logic [31:0] wd, input logic [1:0] sz);
    rv[k][m]  = 1'b1;
    rw[k][m]  = wr;
    ra[k][m]  = a;
    rwd[k][m] = wd;
    rsz[k][m] = sz;
  endtask

  task automatic rand_fill(input int k);
    for (int m = 0; m < 2; m++) begin
      if (!rv[k][m] && ($urandom_range(0, 9) < 6)) begin
        req(k, m, 1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 63)), $urandom,
            ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)));
      end
    end
  endtask

  task automatic check_zero_outs(input int k, input string tag);
    check_eq({tag, "_ctl"}, {20'd0, rdy[k][0], rdy[k][1], sv[k][0], sv[k][1], se[k][0],
                             se[k][1], ram_en[k], ram_we[k], 1'b0}, 32'd0);
    check_eq({tag, "_data"}, ram_addr[k] | ram_wdata[k] | sd[k][0] | sd[k][1], 32'd0);
  endtask

  // One clock of instance k: check outputs at the falling edge, advance the model,
  // then retire the granted request after the rising edge.
  task automatic step(input int k);
    int          g;
    int          off;
    int          nb;
    bit          ill;
    bit          wr_e;
    logic [31:0] a;
    logic [31:0] wd;
    logic        en_e;
    logic [3:0]  we_e;
    logic [31:0] addr_e;
    logic [31:0] wd_e;
    logic [31:0] sd_e;
    logic [1:0]  rdy_e;
    logic [1:0]  sv_e;
    logic [1:0]  se_e;
    @(negedge clk);
    g = -1;
    if (n >= 1 && !(busy && n < rsp_cyc)) begin
      if (rv[k][0] && rv[k][1]) g = 1 - last;
      else if (rv[k][0])        g = 0;
      else if (rv[k][1])        g = 1;
    end
    en_e = 1'b0; we_e = 4'd0; addr_e = 32'd0; wd_e = 32'd0; sd_e = 32'd0;
    rdy_e = 2'b00; sv_e = 2'b00; se_e = 2'b00; ill = 1'b0; wr_e = 1'b0;
    if (g >= 0) begin
      a        = ra[k][g];
      wd       = rwd[k][g];
      rdy_e[g] = 1'b1;
      ill      = is_illegal(rsz[k][g], a);
      if (!ill) begin
        en_e   = 1'b1;
        addr_e = a - (a % 4);
        wr_e   = rw[k][g];
        if (wr_e) begin
          nb  = 1 << rsz[k][g];
          off = int'(a[1:0]);
          for (int i = 0; i < 4; i++) begin
            we_e[i]       = (i >= off) && (i < off + nb);
            wd_e[8*i +: 8] = wd[8*(i % nb) +: 8];
          end
        end
      end
    end
    if (busy && n == rsp_cyc) begin
      sv_e[rm] = 1'b1;
      se_e[rm] = rerr;
      sd_e     = rload ? ram_rdata[k] : 32'd0;
    end
    for (int m = 0; m < 2; m++) begin
      check_eq($sformatf("m%0d_req_ready", m), 32'(rdy[k][m]), 32'(rdy_e[m]));
      check_eq($sformatf("m%0d_rsp_valid", m), 32'(sv[k][m]), 32'(sv_e[m]));
      check_eq($sformatf("m%0d_rsp_err", m), 32'(se[k][m]), 32'(se_e[m]));
      if (sv_e[m]) check_eq($sformatf("m%0d_rsp_rdata", m), sd[k][m], sd_e);
    end
    check_eq("ram_d_en", 32'(ram_en[k]), 32'(en_e));
    check_eq("ram_d_we", 32'(ram_we[k]), 32'(we_e));
    if (en_e) check_eq("ram_d_addr", ram_addr[k], addr_e);
    if (wr_e) check_eq("ram_d_wdata", ram_wdata[k], wd_e);

    if (busy && n == rsp_cyc) busy = 1'b0;
    if (g >= 0) begin
      busy    = 1'b1;
      rm      = g;
      rerr    = ill;
      rload   = !rw[k][g] && !ill;
      rsp_cyc = n + (rload ? lat : 1);
      last    = g;
    end
    n++;
    @(posedge clk);
    #1;
    if (g >= 0) rv[k][g] = 1'b0;
    if (!rd_hold) ram_rdata[k] = $urandom;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    cur     = 0;
    rd_hold = 1'b0;
    rsp_cyc = 0;
    rm      = 0;
    rload   = 1'b0;
    rerr    = 1'b0;
    lat     = 1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      rst_n[k]     = 1'b0;
      ram_rdata[k] = 32'd0;
      for (int m = 0; m < 2; m++) begin
        rv[k][m] = 1'b0; rw[k][m] = 1'b0; ra[k][m] = 32'd0; rwd[k][m] = 32'd0; rsz[k][m] = 2'd0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    check_zero_outs(0, "reset");
    check_zero_outs(1, "reset");

    // ---- RD_LATENCY = 1 ----
    cur = 0; lat = 1;
    rst_n[0] = 1'b1;
    model_reset();
    req(0, 0, 1'b0, 32'h100, 32'd0, 2'd2);
    rd_hold = 1'b1;
    ram_rdata[0] = 32'hDEADBEEF;
    repeat (3) step(0);
    rd_hold = 1'b0;
    req(0, 1, 1'b1, 32'h203, 32'h0000_00A5, 2'd0);
    repeat (2) step(0);
    for (int i = 0; i < 8; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (!rv[0][m]) req(0, m, 1'b1, 32'h300 + 32'(4 * $urandom_range(0, 15)), $urandom, 2'd2);
      end
      step(0);
    end
    rv[0][0] = 1'b0;
    rv[0][1] = 1'b0;
    step(0);
    req(0, 0, 1'b0, 32'h102, 32'd0, 2'd1);
    step(0);
    req(0, 0, 1'b0, 32'h105, 32'd0, 2'd2);
    repeat (3) step(0);
    repeat (600) begin
      rand_fill(0);
      step(0);
    end

    // ---- RD_LATENCY = 3 ----
    cur = 1; lat = 3;
    rst_n[1] = 1'b1;
    model_reset();
    step(1);
    req(1, 0, 1'b0, 32'h100, 32'd0, 2'd2);
    step(1);
    req(1, 1, 1'b1, 32'h204, $urandom, 2'd2);
    repeat (4) step(1);
    // Reset in the cycle after a load grant: in-flight response must vanish
    req(1, 0, 1'b0, 32'h108, 32'd0, 2'd2);
    step(1);
    req(1, 0, 1'b1, 32'h110, $urandom, 2'd2);
    req(1, 1, 1'b1, 32'h114, $urandom, 2'd2);
    rst_n[1] = 1'b0;
    #1;
    check_zero_outs(1, "midrst");
    @(posedge clk);
    #1;
    rst_n[1] = 1'b1;
    model_reset();
    repeat (6) step(1);
    repeat (600) begin
      rand_fill(1);
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
